quarter_window_feeder: RTL and testbench
========================================

Name: quarter_window_feeder

Overview:
Upstream stage of the quarter-pel line filter. It accepts one 8-bit reference pixel per cycle over a valid/ready handshake and assembles 8-pixel (64-bit) windows for the filter. Consecutive windows in a line overlap by one pixel, so the filter's 14-pixel outputs tile the line with no gaps. At the end of a line it pads the final partial window and flags it as last.

Parameters:
PIX_W, 8, bits per pixel; the filter requires 8.
WIN, 8, pixels per window; fixed at 8 to match the filter input width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_pix  input  PIX_W  incoming pixel.
in_valid  input  1  in_pix is valid.
in_last  input  1  in_pix is the last pixel of the line; qualified by in_valid.
in_ready  output  1  feeder accepts in_pix this cycle.
out_pix  output  WIN*PIX_W  window. Pixel k (k=0 is the earliest) is at bits [8k+7:8k].
out_valid  output  1  out_pix holds a complete window.
out_last  output  1  window is the final window of the line; qualified by out_valid.
out_ready  input  1  downstream consumes the window.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state FILL, count 0, window register 0, last flag 0, out_valid 0, out_last 0, out_pix 0. in_ready is 1 after reset because it decodes from FILL.
- Reset mid-operation: an asserted rst_n aborts any state immediately. A partial window or held output is discarded.
- Acceptance: a pixel is accepted when in_valid and in_ready are both 1. While in_ready is 0, upstream holds in_pix, in_valid and in_last stable.
- Slot write: the accepted pixel goes into slot [count], then count increments.
- State FILL:
  - in_ready=1, out_valid=0.
  - Accept with count becoming 8 -> EMIT. The last flag is set to in_last.
  - Accept with in_last=1 and count<8 -> PAD. The last flag is set, and the pad value is held as the just-accepted pixel.
- State PAD:
  - in_ready=0.
  - Writes one pad pixel per cycle into slot [count] and increments count.
  - When count reaches 8 -> EMIT.
  - PAD therefore lasts 8-count cycles.
- State EMIT:
  - out_valid=1, in_ready=0.
  - out_pix and out_last are held stable until out_ready=1.
  - On out_ready=1 with the last flag set: clear the window register, count=0, last flag=0, -> FILL. There is no overlap across lines.
  - On out_ready=1 otherwise: copy slot 7 to slot 0, count=1, -> FILL. This gives the one-pixel overlap.
- Latency: out_valid rises the cycle after the 8th pixel is accepted, or the cycle after the final PAD write.
- Pixels per window:
  - First window of a line consumes 8 input pixels; each later window consumes 7 new pixels.
  - A line of N pixels yields 1 window if N<=8, otherwise 1+ceil((N-8)/7) windows.
- Exact-fit last window: when in_last arrives on the pixel that makes count=8, go directly to EMIT with out_last=1; no padding.
- One-pixel line: count=1 -> 7 PAD cycles -> a window of 8 copies of that pixel.
- in_last while count=0 after a non-last emit cannot occur: count is always >=1 mid-line. in_last always lands in the window it completes.
- Arithmetic: none. Data paths are pure register moves at 8 bits per pixel.

Optional Feature:
Macro QWF_ZERO_PAD_EN.
- Defined: PAD writes 8'h00 into the remaining slots.
- Undefined (default): PAD writes a replica of the last accepted pixel (edge replication).
- State sequence and timing are identical in both builds; only the pad value differs.

Test Plan:
- Line of 15 pixels, values 1..15, out_ready=1 -> window 1 = {1..8} with out_last=0; window 2 = {8..15} with out_last=1; in_ready low 1 cycle per emit.
- Line of 3 pixels 10,20,30 -> 5 PAD cycles, then {10,20,30,30,30,30,30,30} with out_last=1. Built with QWF_ZERO_PAD_EN -> {10,20,30,0,0,0,0,0}.
- Exactly 8 pixels 0x11..0x88 with in_last on the 8th -> one window {0x11..0x88}, out_last=1, no PAD cycles.
- out_ready held 0 for 4 cycles during EMIT -> out_pix and out_last stable, in_ready=0 throughout; window accepted on the 5th cycle and FILL resumes with count=1.
- Two back-to-back lines of 9 pixels (A: 1..9, B: 101..109):
  - Line A -> {1..8}, then {8,9,9,9,9,9,9,9} with out_last=1.
  - Line B -> first window {101..108}; no line-A pixel appears in it.
- rst_n asserted during PAD of a 2-pixel line -> out_valid=0 and out_pix=0 immediately. A fresh 8-pixel line after release yields a correct window.

Source files
------------

// File: rtl/quarter_window_feeder.sv
// Assembles 8-pixel windows with a one-pixel overlap between consecutive windows of a line.
// Optional build macro QWF_ZERO_PAD_EN: pad the final partial window with zeros instead of edge replication.
module quarter_window_feeder #(
  parameter int PIX_W = 8,
  parameter int WIN   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PIX_W-1:0]     in_pix,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [WIN*PIX_W-1:0] out_pix,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready
);

  localparam int CNT_W = $clog2(WIN + 1);
  localparam int IDX_W = $clog2(WIN);

  typedef enum logic [1:0] {FILL, PAD, EMIT} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               last_reg;
  logic [PIX_W-1:0]   pad_reg;
  logic               out_valid_reg;
  logic               out_last_reg;

  logic               accept;
  logic               wr_en;
  logic [PIX_W-1:0]   wr_data;
  logic [IDX_W-1:0]   slot_idx;
  logic [CNT_W-1:0]   count_next;
  logic               emit_hs;
  logic               clear_win;
  logic               overlap;
  logic [PIX_W-1:0]   pad_value;
  logic [PIX_W-1:0]   tail_pix;

  assign in_ready   = (state_reg == FILL);
  assign out_valid  = out_valid_reg;
  assign out_last   = out_last_reg;

  assign accept     = in_valid && (state_reg == FILL);
  assign wr_en      = accept || (state_reg == PAD);
  assign wr_data    = (state_reg == PAD) ? pad_reg : in_pix;
  assign slot_idx   = count_reg[IDX_W-1:0];
  assign count_next = count_reg + CNT_W'(1);
  assign emit_hs    = (state_reg == EMIT) && out_ready;
  assign clear_win  = emit_hs && last_reg;
  assign overlap    = emit_hs && !last_reg;

`ifdef QWF_ZERO_PAD_EN
  assign pad_value = '0;
`else
  assign pad_value = in_pix;
`endif

  // Each slot owns its register; slot 0 additionally takes the overlap pixel from the tail slot.
  genvar gi;
  generate
    for (gi = 0; gi < WIN; gi++) begin : g_slot
      localparam bit IS_HEAD = (gi == 0);
      logic [PIX_W-1:0] slot_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg <= '0;
        end else if (clear_win) begin
          slot_reg <= '0;
        end else if (wr_en && (slot_idx == IDX_W'(gi))) begin
          slot_reg <= wr_data;
        end else if (IS_HEAD && overlap) begin
          slot_reg <= tail_pix;
        end
      end

      assign out_pix[gi*PIX_W +: PIX_W] = slot_reg;
    end
  endgenerate

  assign tail_pix = g_slot[WIN-1].slot_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= FILL;
      count_reg     <= '0;
      last_reg      <= 1'b0;
      pad_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (accept) begin
            count_reg <= count_next;
            if (count_next == CNT_W'(WIN)) begin
              state_reg     <= EMIT;
              last_reg      <= in_last;
              out_valid_reg <= 1'b1;
              out_last_reg  <= in_last;
            end else if (in_last) begin
              state_reg <= PAD;
              last_reg  <= 1'b1;
              pad_reg   <= pad_value;
            end
          end
        end
        PAD: begin
          count_reg <= count_next;
          if (count_next == CNT_W'(WIN)) begin
            state_reg     <= EMIT;
            out_valid_reg <= 1'b1;
            out_last_reg  <= last_reg;
          end
        end
        EMIT: begin
          if (out_ready) begin
            state_reg     <= FILL;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            // A finished line starts empty; mid-line the overlap pixel already sits in slot 0.
            if (last_reg) begin
              count_reg <= '0;
              last_reg  <= 1'b0;
            end else begin
              count_reg <= CNT_W'(1);
            end
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_quarter_window_feeder.sv
// Self-checking bench for quarter_window_feeder: randomized lines checked against a window-list model.
module tb_quarter_window_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_pix = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [63:0] out_pix;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b0;

  quarter_window_feeder dut (
    .clk(clk), .rst_n(rst_n),
    .in_pix(in_pix), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_pix(out_pix), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0]  cur_line[$];
  logic [7:0]  drv_pix[$];
  bit          drv_last[$];
  logic [63:0] exp_win[$];
  bit          exp_last[$];
  logic [63:0] got_win[$];
  bit          got_last[$];
  int          rise_cyc[$];
  int          last_acc_cyc;
  int          exp_pad;
  int          in_ready_err;
  int          stable_err;
  bit          timeout;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_run();
    drv_pix.delete(); drv_last.delete();
    exp_win.delete(); exp_last.delete();
    got_win.delete(); got_last.delete();
    rise_cyc.delete();
    last_acc_cyc = 0; exp_pad = 0;
    in_ready_err = 0; stable_err = 0; timeout = 0;
  endtask

  // Reference model: window k covers line indices 7k..7k+7; indices past the end take the pad value.
  task automatic add_line();
    int n, w;
    logic [7:0] pad;
    logic [63:0] win;
    n = cur_line.size();
    w = (n <= 8) ? 1 : 1 + ((n - 8) + 6) / 7;
`ifdef QWF_ZERO_PAD_EN
    pad = 8'h00;
`else
    pad = cur_line[n-1];
`endif
    for (int k = 0; k < w; k++) begin
      for (int j = 0; j < 8; j++) begin
        int idx;
        idx = 7 * k + j;
        win[8*j +: 8] = (idx < n) ? cur_line[idx] : pad;
      end
      exp_win.push_back(win);
      exp_last.push_back(k == w - 1);
    end
    exp_pad = 8 - (n - 7 * (w - 1));
    for (int i = 0; i < n; i++) begin
      drv_pix.push_back(cur_line[i]);
      drv_last.push_back(i == n - 1);
    end
  endtask

  task automatic drive(input int gap_pct);
    foreach (drv_pix[i]) begin
      bit acc;
      int tries;
      if ($urandom_range(99) < gap_pct) begin
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
      end
      acc = 1'b0;
      tries = 0;
      while (!acc && !timeout) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_pix   = drv_pix[i];
        in_last  = drv_last[i];
        acc = in_ready;
        if (acc && drv_last[i]) last_acc_cyc = cyc + 1;
        @(posedge clk);
        tries++;
        if (tries > 300) timeout = 1'b1;
      end
      if (timeout) break;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // hold >= 0: keep out_ready low for that many cycles of each window; hold < 0: random out_ready.
  task automatic collect(input int hold);
    bit pv, phs, pl;
    logic [63:0] pp;
    int held, n;
    pv = 0; phs = 0; pl = 0; pp = '0; held = 0; n = 0;
    while (got_win.size() < exp_win.size() && !timeout) begin
      @(negedge clk);
      n++;
      if (n > 4000) timeout = 1'b1;
      if (out_valid && !pv) rise_cyc.push_back(cyc);
      if (out_valid && in_ready) in_ready_err++;
      if (pv && !phs && (!out_valid || out_pix !== pp || out_last !== pl)) stable_err++;
      if (hold >= 0) out_ready = out_valid && (held >= hold);
      else           out_ready = 1'($urandom_range(1));
      if (out_valid && !out_ready) held++;
      if (out_valid && out_ready) begin
        got_win.push_back(out_pix);
        got_last.push_back(out_last);
        $display("[cyc %0d] window %h last %0d", cyc, out_pix, out_last);
        held = 0;
      end
      pv = out_valid; pp = out_pix; pl = out_last; phs = out_valid && out_ready;
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run(input int gap_pct, input int hold);
    fork
      drive(gap_pct);
      collect(hold);
    join
  endtask

  task automatic test_reset();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b need 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (out_last !== 1'b0) $display("FAIL reset out_last: got %b need 0", out_last); else pass_cnt++;
    total_cnt++;
    if (out_pix !== 64'h0) $display("FAIL reset out_pix: got %h need 0", out_pix); else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b need 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_line15();
    clear_run();
    cur_line.delete();
    for (int i = 1; i <= 15; i++) cur_line.push_back(8'(i));
    add_line();
    run(0, 0);
    total_cnt++;
    if (timeout || got_win.size() != exp_win.size())
      $display("FAIL line15 count: got %0d need %0d timeout %0d", got_win.size(), exp_win.size(), timeout);
    else pass_cnt++;
    foreach (exp_win[i]) begin
      logic [63:0] gw; bit gl;
      gw = 'x; gl = 0;
      if (i < got_win.size()) begin gw = got_win[i]; gl = got_last[i]; end
      total_cnt++;
      if (gw !== exp_win[i] || gl !== exp_last[i])
        $display("FAIL line15 win%0d: got %h last %0d need %h last %0d", i, gw, gl, exp_win[i], exp_last[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (in_ready_err !== 0) $display("FAIL line15 in_ready during emit: got %0d need 0", in_ready_err); else pass_cnt++;
    total_cnt++;
    if (rise_cyc.size() == 0 || rise_cyc[$] - last_acc_cyc != exp_pad)
      $display("FAIL line15 pad cycles: got %0d need %0d", (rise_cyc.size() == 0) ? -1 : rise_cyc[$] - last_acc_cyc, exp_pad);
    else pass_cnt++;
  endtask

  task automatic test_short_line();
    clear_run();
    cur_line = '{8'd10, 8'd20, 8'd30};
    add_line();
    run(0, 0);
    total_cnt++;
    if (timeout || got_win.size() != 1)
      $display("FAIL short count: got %0d need 1 timeout %0d", got_win.size(), timeout);
    else pass_cnt++;
    if (got_win.size() > 0) begin
      total_cnt++;
      if (got_win[0] !== exp_win[0] || got_last[0] !== 1'b1)
        $display("FAIL short window: got %h last %0d need %h last 1", got_win[0], got_last[0], exp_win[0]);
      else pass_cnt++;
    end
    total_cnt++;
    if (rise_cyc.size() == 0 || rise_cyc[$] - last_acc_cyc != 5)
      $display("FAIL short pad cycles: got %0d need 5", (rise_cyc.size() == 0) ? -1 : rise_cyc[$] - last_acc_cyc);
    else pass_cnt++;
  endtask

  task automatic test_exact8();
    clear_run();
    cur_line.delete();
    for (int i = 1; i <= 8; i++) cur_line.push_back(8'(8'h11 * i));
    add_line();
    run(0, 0);
    total_cnt++;
    if (timeout || got_win.size() != 1 || got_win[0] !== 64'h8877665544332211 || got_last[0] !== 1'b1)
      $display("FAIL exact8 window: got %h last %0d count %0d need 8877665544332211 last 1",
               (got_win.size() > 0) ? got_win[0] : 64'hx, (got_last.size() > 0) ? got_last[0] : 1'b0, got_win.size());
    else pass_cnt++;
    total_cnt++;
    if (rise_cyc.size() == 0 || rise_cyc[$] - last_acc_cyc != 0)
      $display("FAIL exact8 pad cycles: got %0d need 0", (rise_cyc.size() == 0) ? -1 : rise_cyc[$] - last_acc_cyc);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    clear_run();
    cur_line.delete();
    for (int i = 0; i < 15; i++) cur_line.push_back(8'($urandom_range(255)));
    add_line();
    run(0, 4);
    total_cnt++;
    if (timeout || got_win.size() != exp_win.size())
      $display("FAIL hold count: got %0d need %0d timeout %0d", got_win.size(), exp_win.size(), timeout);
    else pass_cnt++;
    foreach (exp_win[i]) begin
      logic [63:0] gw; bit gl;
      gw = 'x; gl = 0;
      if (i < got_win.size()) begin gw = got_win[i]; gl = got_last[i]; end
      total_cnt++;
      if (gw !== exp_win[i] || gl !== exp_last[i])
        $display("FAIL hold win%0d: got %h last %0d need %h last %0d", i, gw, gl, exp_win[i], exp_last[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (stable_err !== 0) $display("FAIL hold stability: got %0d changes need 0", stable_err); else pass_cnt++;
    total_cnt++;
    if (in_ready_err !== 0) $display("FAIL hold in_ready: got %0d high cycles need 0", in_ready_err); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    clear_run();
    cur_line.delete();
    for (int i = 1; i <= 9; i++) cur_line.push_back(8'(i));
    add_line();
    cur_line.delete();
    for (int i = 101; i <= 109; i++) cur_line.push_back(8'(i));
    add_line();
    run(0, -1);
    total_cnt++;
    if (timeout || got_win.size() != exp_win.size())
      $display("FAIL b2b count: got %0d need %0d timeout %0d", got_win.size(), exp_win.size(), timeout);
    else pass_cnt++;
    foreach (exp_win[i]) begin
      logic [63:0] gw; bit gl;
      gw = 'x; gl = 0;
      if (i < got_win.size()) begin gw = got_win[i]; gl = got_last[i]; end
      total_cnt++;
      if (gw !== exp_win[i] || gl !== exp_last[i])
        $display("FAIL b2b win%0d: got %h last %0d need %h last %0d", i, gw, gl, exp_win[i], exp_last[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (stable_err !== 0) $display("FAIL b2b stability: got %0d changes need 0", stable_err); else pass_cnt++;
  endtask

  task automatic test_random_lines();
    clear_run();
    for (int l = 0; l < 6; l++) begin
      int n;
      n = $urandom_range(30, 1);
      cur_line.delete();
      for (int i = 0; i < n; i++) cur_line.push_back(8'($urandom_range(255)));
      add_line();
    end
    run(30, -1);
    total_cnt++;
    if (timeout || got_win.size() != exp_win.size())
      $display("FAIL random count: got %0d need %0d timeout %0d", got_win.size(), exp_win.size(), timeout);
    else pass_cnt++;
    foreach (exp_win[i]) begin
      logic [63:0] gw; bit gl;
      gw = 'x; gl = 0;
      if (i < got_win.size()) begin gw = got_win[i]; gl = got_last[i]; end
      total_cnt++;
      if (gw !== exp_win[i] || gl !== exp_last[i])
        $display("FAIL random win%0d: got %h last %0d need %h last %0d", i, gw, gl, exp_win[i], exp_last[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (stable_err !== 0 || in_ready_err !== 0)
      $display("FAIL random protocol: got stable %0d in_ready %0d need 0 0", stable_err, in_ready_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_pad();
    @(negedge clk);
    in_valid = 1'b1; in_pix = 8'hA5; in_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_pix = 8'h5A; in_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL midreset out_valid: got %b need 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (out_pix !== 64'h0) $display("FAIL midreset out_pix: got %h need 0", out_pix); else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL midreset in_ready: got %b need 1", in_ready); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    clear_run();
    cur_line.delete();
    for (int i = 0; i < 8; i++) cur_line.push_back(8'($urandom_range(255)));
    add_line();
    run(0, 0);
    total_cnt++;
    if (timeout || got_win.size() != 1 || got_win[0] !== exp_win[0] || got_last[0] !== 1'b1)
      $display("FAIL midreset fresh line: got %h count %0d need %h last 1",
               (got_win.size() > 0) ? got_win[0] : 64'hx, got_win.size(), exp_win[0]);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_line15();
    test_short_line();
    test_exact8();
    test_hold();
    test_back_to_back();
    test_random_lines();
    test_reset_mid_pad();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
